// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the VGA raster generator.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Colour bar i: each index bit drives one primary fully on or off.
  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    c.r = idx[2] ? 8'hFF : 8'h00;
    c.g = idx[1] ? 8'hFF : 8'h00;
    c.b = idx[0] ? 8'hFF : 8'h00;
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK region decode.
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  inc,
  output logic [9:0]            count,
  output vga_pkg::axis_state_t  state,
  output logic                  wrap
);

  localparam logic [9:0] LAST        = 10'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [9:0] FRONT_START = 10'(ACTIVE);
  localparam logic [9:0] SYNC_START  = 10'(ACTIVE + FP);
  localparam logic [9:0] BACK_START  = 10'(ACTIVE + FP + SYNC);

  assign wrap = inc && (count == LAST);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)    count <= '0;
    else if (inc) count <= (count == LAST) ? '0 : count + 10'd1;
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    state = vga_pkg::ACTIVE;
    if (count >= BACK_START)       state = vga_pkg::BACK;
    else if (count >= SYNC_START)  state = vga_pkg::SYNC;
    else if (count >= FRONT_START) state = vga_pkg::FRONT;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing and registered output stage; `VGA_TEST_PATTERN_EN adds a colour-bar
// test_mode input that overrides the engine RGB.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       Clk,
  input  logic       Reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic       pixel_clk,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       frame_start,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int             DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  axis_state_t      h_state, v_state;
  logic             h_wrap;
  logic             hs_raw, vs_raw;
  logic             blank_d;
  rgb_t             engine_rgb, src_rgb, rgb_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) div_cnt <= '0;
    else       div_cnt <= pixel_clk ? '0 : div_cnt + DIV_W'(1);
  end

  assign pixel_clk = (div_cnt == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
  ) u_h (
    .Clk (Clk), .Reset (Reset), .inc (pixel_clk),
    .count (DrawX), .state (h_state), .wrap (h_wrap)
  );

  // h_wrap already implies pixel_clk; the vertical wrap is exactly the last pixel of the frame.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
  ) u_v (
    .Clk (Clk), .Reset (Reset), .inc (h_wrap),
    .count (DrawY), .state (v_state), .wrap (frame_start)
  );

  assign blank  = (h_state == ACTIVE) && (v_state == ACTIVE);
  assign hs_raw = (h_state != SYNC);
  assign vs_raw = (v_state != SYNC);
  assign sync   = 1'b0;

  assign engine_rgb = {Red_in, Green_in, Blue_in};

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_idx;

  // Leftmost bar is index 7 (white), counting down to 0 (black) at the right edge.
  always_comb begin
    bar_idx = 3'd7;
    for (int k = 1; k < 8; k++)
      if (DrawX >= 10'(k * BAR_W)) bar_idx = 3'(7 - k);
  end

  assign src_rgb = test_mode ? bar_color(bar_idx) : engine_rgb;
`else
  assign src_rgb = engine_rgb;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs      <= 1'b1;
      vs      <= 1'b1;
      blank_d <= 1'b0;
      rgb_q   <= '0;
    end else if (pixel_clk) begin
      hs      <= hs_raw;
      vs      <= vs_raw;
      blank_d <= blank;
      rgb_q   <= blank ? src_rgb : '0;
    end
  end

  // blank_d and rgb_q load together, so this gate only reinforces the blanking already registered.
  assign VGA_R = blank_d ? rgb_q.r : 8'h00;
  assign VGA_G = blank_d ? rgb_q.g : 8'h00;
  assign VGA_B = blank_d ? rgb_q.b : 8'h00;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance plus a short-frame instance.
module tb_vga_timing_gen;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Red_in = 8'h00, Green_in = 8'h00, Blue_in = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  logic       pixel_clk, blank, frame_start, hs, vs, sync;
  logic [9:0] DrawX, DrawY;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  logic       f_pixel_clk, f_blank, f_frame_start, f_hs, f_vs, f_sync;
  logic [9:0] f_DrawX, f_DrawY;
  logic [7:0] f_VGA_R, f_VGA_G, f_VGA_B;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;

  always #5 Clk = ~Clk;

  vga_timing_gen dut (
    .Clk (Clk), .Reset (Reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode (test_mode),
`endif
    .Red_in (Red_in), .Green_in (Green_in), .Blue_in (Blue_in),
    .pixel_clk (pixel_clk), .DrawX (DrawX), .DrawY (DrawY), .blank (blank),
    .frame_start (frame_start), .hs (hs), .vs (vs), .sync (sync),
    .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B)
  );

  // Short vertical timing (12 lines, sync on lines 8..9) keeps whole frames affordable.
  vga_timing_gen #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_f (
    .Clk (Clk), .Reset (Reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode (test_mode),
`endif
    .Red_in (Red_in), .Green_in (Green_in), .Blue_in (Blue_in),
    .pixel_clk (f_pixel_clk), .DrawX (f_DrawX), .DrawY (f_DrawY), .blank (f_blank),
    .frame_start (f_frame_start), .hs (f_hs), .vs (f_vs), .sync (f_sync),
    .VGA_R (f_VGA_R), .VGA_G (f_VGA_G), .VGA_B (f_VGA_B)
  );

  // One Clk; samples are taken on the falling edge after each rising edge.
  task automatic tick();
    @(posedge Clk);
    edges++;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    edges = 0;
  endtask

  task automatic test_reset();
    Red_in = 8'hFF; Green_in = 8'h00; Blue_in = 8'h00;
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    vectors++; if (hs !== 1'b1) begin miscompares++; $display("FAIL reset_hs: got %b expected 1", hs); end
    vectors++; if (vs !== 1'b1) begin miscompares++; $display("FAIL reset_vs: got %b expected 1", vs); end
    vectors++; if (VGA_R !== 8'h00) begin miscompares++; $display("FAIL reset_r: got %h expected 00", VGA_R); end
    vectors++; if (pixel_clk !== 1'b0) begin miscompares++; $display("FAIL reset_pclk: got %b expected 0", pixel_clk); end
    vectors++; if ({DrawX, DrawY} !== 20'd0) begin miscompares++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", DrawX, DrawY); end
    vectors++; if (sync !== 1'b0) begin miscompares++; $display("FAIL sync_const: got %b expected 0", sync); end
    Reset = 1'b0;
    edges = 0;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (pixel_clk !== 1'(edges % 2)) begin
        miscompares++; $display("FAIL pclk_edge%0d: got %b expected %0d", edges, pixel_clk, edges % 2);
      end
      vectors++;
      if (DrawX !== 10'(edges / 2) || DrawY !== 10'd0) begin
        miscompares++; $display("FAIL startup_xy_edge%0d: got %0d,%0d expected %0d,0", edges, DrawX, DrawY, edges / 2);
      end
      vectors++;
      if (VGA_R !== ((edges >= 2) ? 8'hFF : 8'h00) || hs !== 1'b1 || vs !== 1'b1) begin
        miscompares++; $display("FAIL startup_out_edge%0d: got r=%h hs=%b vs=%b", edges, VGA_R, hs, vs);
      end
      tick();
    end
  endtask

  task automatic test_line();
    int p, r_cnt, hs_cnt, hs_first;
    logic [7:0] er;
    logic eh;
    r_cnt = 0; hs_cnt = 0; hs_first = -1;
    Red_in = 8'hFF; Green_in = 8'h00; Blue_in = 8'h00;
    do_reset();
    while (edges < 1602) begin
      tick();
      if (edges == 1600) begin
        vectors++;
        if (DrawX !== 10'd0 || DrawY !== 10'd1) begin
          miscompares++; $display("FAIL line_period: got %0d,%0d expected 0,1", DrawX, DrawY);
        end
      end
      if (edges % 2 == 0) begin
        p  = edges / 2 - 1;
        er = (p % 800 < 640 && p < 480 * 800) ? 8'hFF : 8'h00;
        eh = !(p % 800 >= 656 && p % 800 < 752);
        vectors++;
        if (VGA_R !== er || VGA_G !== 8'h00) begin
          miscompares++; $display("FAIL line_rgb_p%0d: got r=%h g=%h expected r=%h g=00", p, VGA_R, VGA_G, er);
        end
        vectors++;
        if (hs !== eh) begin
          miscompares++; $display("FAIL line_hs_p%0d: got %b expected %b", p, hs, eh);
        end
        if (p < 800) begin
          if (VGA_R === 8'hFF) r_cnt++;
          if (hs === 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = edges / 2;
          end
        end
      end
    end
    vectors++; if (r_cnt != 640) begin miscompares++; $display("FAIL red_pixels: got %0d expected 640", r_cnt); end
    vectors++; if (hs_cnt != 96) begin miscompares++; $display("FAIL hs_width: got %0d expected 96", hs_cnt); end
    vectors++; if (hs_first != 657) begin miscompares++; $display("FAIL hs_start: got %0d expected 657", hs_first); end
  endtask

  task automatic test_blanking();
    int p, hc;
    logic [23:0] ergb;
    Red_in = 8'h12; Green_in = 8'h34; Blue_in = 8'h56;
    do_reset();
    while (edges < 1604) begin
      tick();
      if (edges % 2 == 0) begin
        hc = (edges / 2) % 800;
        vectors++;
        if (blank !== (hc < 640)) begin
          miscompares++; $display("FAIL blank_hc%0d: got %b expected %b", hc, blank, hc < 640);
        end
        p    = edges / 2 - 1;
        ergb = (p % 800 < 640) ? 24'h123456 : 24'h000000;
        vectors++;
        if ({VGA_R, VGA_G, VGA_B} !== ergb) begin
          miscompares++; $display("FAIL blank_rgb_p%0d: got %h expected %h", p, {VGA_R, VGA_G, VGA_B}, ergb);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    Red_in = 8'hFF; Green_in = 8'h00; Blue_in = 8'h00;
    do_reset();
    while (edges < 2200) tick();
    vectors++;
    if (DrawX !== 10'd300 || DrawY !== 10'd1 || VGA_R !== 8'hFF) begin
      miscompares++; $display("FAIL pre_reset: got x=%0d y=%0d r=%h expected 300,1,FF", DrawX, DrawY, VGA_R);
    end
    Reset = 1'b1;
    #1;
    vectors++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0) begin
      miscompares++; $display("FAIL async_xy: got %0d,%0d expected 0,0", DrawX, DrawY);
    end
    vectors++;
    if (VGA_R !== 8'h00 || hs !== 1'b1 || vs !== 1'b1 || pixel_clk !== 1'b0) begin
      miscompares++; $display("FAIL async_out: got r=%h hs=%b vs=%b pclk=%b", VGA_R, hs, vs, pixel_clk);
    end
    @(negedge Clk);
    Reset = 1'b0;
    edges = 0;
    tick(); tick();
    vectors++;
    if (DrawX !== 10'd1 || DrawY !== 10'd0) begin
      miscompares++; $display("FAIL restart_xy: got %0d,%0d expected 1,0", DrawX, DrawY);
    end
  endtask

  task automatic test_frame();
    int p, pv, m, vs_cnt, vs_first, fs_first, fs_second;
    logic efs, evs;
    vs_cnt = 0; vs_first = -1; fs_first = -1; fs_second = -1;
    Red_in = 8'h00; Green_in = 8'h00; Blue_in = 8'h00;
    do_reset();
    while (edges < 38400) begin
      tick();
      m   = edges / 2;
      efs = (edges % 2 == 1) && (m % 800 == 799) && ((m / 800) % 12 == 11);
      vectors++;
      if (f_frame_start !== efs) begin
        miscompares++; $display("FAIL frame_start_edge%0d: got %b expected %b", edges, f_frame_start, efs);
      end
      if (f_frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = edges;
        else if (fs_second < 0) fs_second = edges;
      end
      if (edges % 2 == 0) begin
        p   = m - 1;
        pv  = (p / 800) % 12;
        evs = !(pv == 8 || pv == 9);
        vectors++;
        if (f_vs !== evs) begin
          miscompares++; $display("FAIL vs_p%0d: got %b expected %b", p, f_vs, evs);
        end
        if (p < 9600 && f_vs === 1'b0) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = m;
        end
      end
    end
    vectors++; if (vs_cnt != 1600) begin miscompares++; $display("FAIL vs_width: got %0d expected 1600", vs_cnt); end
    vectors++; if (vs_first != 6401) begin miscompares++; $display("FAIL vs_start: got %0d expected 6401", vs_first); end
    vectors++; if (fs_first != 19199) begin miscompares++; $display("FAIL fs_first: got %0d expected 19199", fs_first); end
    vectors++;
    if (fs_second - fs_first != 19200) begin
      miscompares++; $display("FAIL fs_spacing: got %0d expected 19200", fs_second - fs_first);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int pix[5];
    logic [23:0] col[5];
    int p;
    pix = '{0, 79, 80, 560, 639};
    col = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'h000000};
    Red_in = 8'hAA; Green_in = 8'h55; Blue_in = 8'hAA;
    test_mode = 1'b1;
    do_reset();
    while (edges < 1284) begin
      tick();
      if (edges % 2 == 0) begin
        p = edges / 2 - 1;
        for (int i = 0; i < 5; i++) begin
          if (p == pix[i]) begin
            vectors++;
            if ({VGA_R, VGA_G, VGA_B} !== col[i]) begin
              miscompares++; $display("FAIL bar_p%0d: got %h expected %h", p, {VGA_R, VGA_G, VGA_B}, col[i]);
            end
          end
        end
      end
    end
    test_mode = 1'b0;
    do_reset();
    tick(); tick();
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hAA55AA) begin
      miscompares++; $display("FAIL pattern_off: got %h expected AA55AA", {VGA_R, VGA_G, VGA_B});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_blanking();
    test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    test_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
